// File: rtl/if_id_stage_pkg.sv
// Shared pipeline constants and IF/ID payload type for the fetch/decode boundary.
package if_id_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    // Instruction word used for bubbles and flushed slots
    localparam logic [XLEN-1:0] NOP_WORD = XLEN'(0);
    // Sequential fetch increment
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    // Source register fields of an R/I-type instruction word
    localparam int unsigned RS_HI = 25;
    localparam int unsigned RS_LO = 21;
    localparam int unsigned RT_HI = 20;
    localparam int unsigned RT_LO = 16;

    // Per-cycle operating mode of the stage, highest priority first
    typedef enum logic [1:0] {
        MODE_FLUSH   = 2'd0,
        MODE_STALL   = 2'd1,
        MODE_ADVANCE = 2'd2
    } mode_e;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    function automatic logic [REG_W-1:0] rs_field(input logic [XLEN-1:0] instr);
        return instr[RS_HI:RS_LO];
    endfunction

    function automatic logic [REG_W-1:0] rt_field(input logic [XLEN-1:0] instr);
        return instr[RT_HI:RT_LO];
    endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// Load-use hazard: a load in ID/EX writes a register read by the instruction in IF/ID.
module load_use_detect
    import if_id_stage_pkg::*;
(
    input  logic             mem_read_id_ex,
    input  logic [REG_W-1:0] rt_id_ex,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_valid,
    output logic             hazard
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency
    always_comb begin
        hazard = mem_read_id_ex && ifid_valid && (rt_id_ex != REG_W'(0)) &&
                 ((rt_id_ex == ifid_rs) || (rt_id_ex == ifid_rt));
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch PC register, IF/ID pipeline register and stall counter with flush/stall control.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  instr_in,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             MemToRead_ID_EX,
    input  logic [REG_W-1:0] Instruccion_RT_ID_EX,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  sumador_IF_ID,
    output logic [XLEN-1:0]  instruccion_IF_ID,
    output logic             valid_IF_ID,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    logic [XLEN-1:0]  pc_q, pc_d;
    ifid_t            ifid_q, ifid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;
    mode_e            mode_c;
    logic [XLEN-1:0]  pc_next_seq;

    load_use_detect u_load_use_detect (
        .mem_read_id_ex (MemToRead_ID_EX),
        .rt_id_ex       (Instruccion_RT_ID_EX),
        .ifid_rs        (rs_field(ifid_q.instr)),
        .ifid_rt        (rt_field(ifid_q.instr)),
        .ifid_valid     (ifid_q.valid),
        .hazard         (hazard)
    );

    // Mode selection: a taken branch squashes both the stall and the fetch
    always_comb begin
        mode_c = MODE_ADVANCE;
        if (branch_taken) begin
            mode_c = MODE_FLUSH;
        end else if (hazard) begin
            mode_c = MODE_STALL;
        end
    end

    // Next-state for PC, IF/ID and counter; PC+4 wraps naturally at 32 bits
    always_comb begin
        pc_d        = pc_q;
        ifid_d      = ifid_q;
        cnt_d       = cnt_q;
        pc_next_seq = pc_q + PC_STEP;
        unique case (mode_c)
            MODE_FLUSH: begin
                pc_d            = branch_target & ~XLEN'(3);
                ifid_d.instr    = NOP_WORD;
                ifid_d.pc_plus4 = XLEN'(0);
                ifid_d.valid    = 1'b0;
            end
            MODE_STALL: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MODE_ADVANCE: begin
                pc_d            = pc_next_seq;
                ifid_d.instr    = instr_in;
                ifid_d.pc_plus4 = pc_next_seq;
                ifid_d.valid    = 1'b1;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            ifid_q.instr    <= NOP_WORD;
            ifid_q.pc_plus4 <= XLEN'(0);
            ifid_q.valid    <= 1'b0;
            cnt_q           <= CNT_W'(0);
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pc_out            = pc_q;
    assign sumador_IF_ID     = ifid_q.pc_plus4;
    assign instruccion_IF_ID = ifid_q.instr;
    assign valid_IF_ID       = ifid_q.valid;
    assign stall_count       = cnt_q;
    assign stall             = (mode_c == MODE_STALL);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reference model plus literal spot checks.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr_in = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        mem_rd = 1'b0;
    logic [4:0]  rt_ex = 5'd0;

    logic [31:0] pc_out, sum_o, ir_o;
    logic        valid_o, stall_o;
    logic [15:0] cnt_o;
    logic [31:0] pc4, sum4, ir4;
    logic        valid4, stall4;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    // reference model state
    logic [31:0] m_pc, m_ir, m_sum;
    logic        m_v;
    int          m_cnt16, m_cnt4;

    localparam logic [31:0] DEP_ADD = 32'h0109_5020; // add $10,$8,$9

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .MemToRead_ID_EX(mem_rd), .Instruccion_RT_ID_EX(rt_ex),
        .pc_out(pc_out), .sumador_IF_ID(sum_o), .instruccion_IF_ID(ir_o),
        .valid_IF_ID(valid_o), .stall(stall_o), .stall_count(cnt_o)
    );

    if_id_stage #(.RESET_PC(32'h0), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .MemToRead_ID_EX(mem_rd), .Instruccion_RT_ID_EX(rt_ex),
        .pc_out(pc4), .sumador_IF_ID(sum4), .instruccion_IF_ID(ir4),
        .valid_IF_ID(valid4), .stall(stall4), .stall_count(cnt4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        bit dep;
        dep = (rt_ex != 5'd0) && ((rt_ex == m_ir[25:21]) || (rt_ex == m_ir[20:16]));
        return mem_rd && m_v && dep && !branch_taken;
    endfunction

    // reference model: one mode per cycle, flush over stall over advance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_ir = 32'h0; m_sum = 32'h0; m_v = 1'b0;
            m_cnt16 = 0; m_cnt4 = 0;
        end else if (branch_taken) begin
            m_pc  = {branch_target[31:2], 2'b00};
            m_ir  = 32'h0; m_sum = 32'h0; m_v = 1'b0;
        end else if (m_stall()) begin
            m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
            m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
        end else begin
            m_ir  = instr_in;
            m_sum = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            m_pc  = m_sum;
            m_v   = 1'b1;
        end
    end

    // compare both instances against the model every cycle
    always @(negedge clk) begin
        if (armed) begin
            chk("m_pc",     64'(pc_out),  64'(m_pc));
            chk("m_ir",     64'(ir_o),    64'(m_ir));
            chk("m_sum",    64'(sum_o),   64'(m_sum));
            chk("m_valid",  64'(valid_o), 64'(m_v));
            chk("m_stall",  64'(stall_o), 64'(m_stall()));
            chk("m_cnt16",  64'(cnt_o),   64'(m_cnt16));
            chk("m_cnt4",   64'(cnt4),    64'(m_cnt4));
            chk("m_pc_w4",  64'(pc4),     64'(m_pc));
            chk("m_stall4", 64'(stall4),  64'(m_stall()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    64'(pc_out),  64'h0);
        chk({tag, "_ir"},    64'(ir_o),    64'h0);
        chk({tag, "_sum"},   64'(sum_o),   64'h0);
        chk({tag, "_valid"}, 64'(valid_o), 64'h0);
        chk({tag, "_cnt"},   64'(cnt_o),   64'h0);
        chk({tag, "_cnt4"},  64'(cnt4),    64'h0);
        chk({tag, "_stall"}, 64'(stall_o), 64'h0);
    endtask

    typedef struct {
        bit          br;
        logic [31:0] tgt;
        bit          mr;
        logic [4:0]  rt;
        logic [31:0] ins;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0, 32'h0,    0, 5'd0, DEP_ADD};
        vecs[1] = '{0, 32'h0,    1, 5'd9, 32'h8D2A_0000};
        vecs[2] = '{0, 32'h0,    1, 5'd9, 32'h0000_0000};
        vecs[3] = '{0, 32'h0,    1, 5'd8, 32'h012A_4020};
        vecs[4] = '{0, 32'h0,    1, 5'd9, 32'h012A_4020};
        vecs[5] = '{1, 32'h100,  1, 5'd9, 32'h1111_1111};
        vecs[6] = '{0, 32'h0,    1, 5'd9, 32'h0128_5820};
        vecs[7] = '{0, 32'h0,    1, 5'd11, 32'h2222_2222};
        vecs[8] = '{0, 32'h0,    0, 5'd11, 32'h3333_3333};
        vecs[9] = '{1, 32'h202,  0, 5'd0, 32'h4444_4444};

        #1 rst_n = 1'b0;
        armed = 1'b1;
        #1 chk_reset("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // sequential fetch from RESET_PC
        instr_in = 32'hAAAA_0001; tick();
        chk("adv1_pc", 64'(pc_out), 64'd4); chk("adv1_sum", 64'(sum_o), 64'd4);
        chk("adv1_valid", 64'(valid_o), 64'd1); chk("adv1_ir", 64'(ir_o), 64'hAAAA_0001);
        instr_in = 32'h2222_0002; tick();
        chk("adv2_pc", 64'(pc_out), 64'd8); chk("adv2_sum", 64'(sum_o), 64'd8);
        instr_in = 32'h3333_0003; tick();
        chk("adv3_pc", 64'(pc_out), 64'd12); chk("adv3_sum", 64'(sum_o), 64'd12);
        instr_in = DEP_ADD; tick();
        chk("adv4_pc", 64'(pc_out), 64'd16);

        // load-use on rs: one stall cycle, then bubble clears it
        mem_rd = 1'b1; rt_ex = 5'd8; #1;
        chk("lu_stall", 64'(stall_o), 64'd1);
        tick();
        chk("lu_pc_held", 64'(pc_out), 64'd16);
        chk("lu_ir_held", 64'(ir_o), 64'(DEP_ADD));
        chk("lu_cnt", 64'(cnt_o), 64'd1);
        mem_rd = 1'b0; rt_ex = 5'd0; #1;
        chk("lu_release", 64'(stall_o), 64'd0);
        tick();
        chk("lu_adv_pc", 64'(pc_out), 64'd20);

        // rt=0 load never stalls
        mem_rd = 1'b1; rt_ex = 5'd0; #1;
        chk("r0_stall", 64'(stall_o), 64'd0);
        tick();
        chk("r0_pc", 64'(pc_out), 64'd24);
        chk("r0_cnt", 64'(cnt_o), 64'd1);

        // branch coinciding with hazard (rt match) flushes
        rt_ex = 5'd9; branch_taken = 1'b1; branch_target = 32'h0000_0043; #1;
        chk("br_stall", 64'(stall_o), 64'd0);
        tick();
        chk("br_pc", 64'(pc_out), 64'h40);
        chk("br_ir", 64'(ir_o), 64'h0);
        chk("br_valid", 64'(valid_o), 64'd0);
        chk("br_cnt", 64'(cnt_o), 64'd1);

        // PC wrap at the top of the address space
        mem_rd = 1'b0; branch_target = 32'hFFFF_FFFF; tick();
        chk("wrap_pre", 64'(pc_out), 64'hFFFF_FFFC);
        branch_taken = 1'b0; tick();
        chk("wrap_pc", 64'(pc_out), 64'h0);
        chk("wrap_sum", 64'(sum_o), 64'h0);
        chk("wrap_valid", 64'(valid_o), 64'd1);

        // long hazard: narrow counter saturates, wide one keeps counting
        mem_rd = 1'b1; rt_ex = 5'd8;
        repeat (20) tick();
        chk("sat_cnt4", 64'(cnt4), 64'hF);
        chk("sat_cnt16", 64'(cnt_o), 64'd21);
        chk("sat_pc", 64'(pc_out), 64'd0);
        chk("sat_stall", 64'(stall_o), 64'd1);

        // asynchronous reset between edges, mid-stall
        #2 rst_n = 1'b0;
        #1 chk_reset("areset");
        tick();
        rst_n = 1'b1; mem_rd = 1'b0; rt_ex = 5'd0;

        // mixed directed vectors, checked by the model each cycle
        foreach (vecs[i]) begin
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            mem_rd        = vecs[i].mr;
            rt_ex         = vecs[i].rt;
            instr_in      = vecs[i].ins;
            tick();
        end
        branch_taken = 1'b0; mem_rd = 1'b0;
        tick();
        chk("end_pc", 64'(pc_out), 64'h204);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-003 SHALL have one clock, clk; reset is asynchronous and active-low, port rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 instr_in  input  32  instruction memory read data for the current pc_out, combinational.
REQ-007 branch_taken  input  1  branch resolved taken in a later stage; redirect and flush.
REQ-008 branch_target  input  32  redirect address, valid when branch_taken=1.
REQ-009 MemToRead_ID_EX  input  1  instruction in ID/EX is a load.
REQ-010 Instruccion_RT_ID_EX  input  5  destination (rt) of the instruction in ID/EX.
REQ-011 pc_out  output  32  current fetch address to instruction memory.
REQ-012 sumador_IF_ID  output  32  registered PC+4 of the fetched instruction.
REQ-013 instruccion_IF_ID  output  32  registered instruction word.
REQ-014 valid_IF_ID  output  1  registered; 1 = instruccion_IF_ID is a real instruction.
REQ-015 stall  output  1  combinational; decode forces ID/EX control bits to 0 when high.
REQ-016 stall_count  output  CNT_W  registered count of stall cycles.

Function
REQ-017 Each cycle SHALL take exactly one mode, priority FLUSH > STALL > ADVANCE.
REQ-018 hazard SHALL equal MemToRead_ID_EX & valid_IF_ID & (Instruccion_RT_ID_EX != 0) & (Instruccion_RT_ID_EX == instruccion_IF_ID[25:21] | Instruccion_RT_ID_EX == instruccion_IF_ID[20:16]).
REQ-019 stall SHALL equal hazard & ~branch_taken.
REQ-020 FLUSH (branch_taken=1) SHALL load pc_out with {branch_target[31:2],2'b00}, and load instruccion_IF_ID=32'h0, sumador_IF_ID=32'h0, valid_IF_ID=0.
REQ-021 STALL SHALL hold pc_out, instruccion_IF_ID, sumador_IF_ID and valid_IF_ID unchanged.
REQ-022 ADVANCE SHALL load instruccion_IF_ID=instr_in, sumador_IF_ID=pc_out+4, valid_IF_ID=1, and pc_out=pc_out+4.
REQ-023 PC+4 SHALL be computed modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 Fetch-to-IF/ID latency SHALL be one cycle; a redirect takes effect on pc_out the cycle after branch_taken.
REQ-025 stall_count SHALL increment by 1 on every cycle with stall=1 and saturate at all-ones.
REQ-026 A load-use stall SHALL last exactly one cycle when ID/EX receives the bubble; back-to-back hazards SHALL produce back-to-back stalls without special-casing.
REQ-027 branch_taken coinciding with hazard SHALL flush, leave stall=0, and leave stall_count unchanged.

Reset
REQ-028 rst_n=0 SHALL immediately set pc_out=RESET_PC, instruccion_IF_ID=0, sumador_IF_ID=0, valid_IF_ID=0, stall_count=0, independent of clk.
REQ-029 stall SHALL be 0 during reset because valid_IF_ID=0.
REQ-030 After reset deassertion, the first rising edge SHALL perform ADVANCE from RESET_PC unless branch_taken=1.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override; no partial state survives.

Structure
REQ-032 A shared pipeline package SHALL hold the NOP word (32'h0), PC_STEP (4), and the rs/rt bit-field positions (25:21, 20:16).
REQ-033 Hazard detection SHALL be one combinational sub-module, load_use_detect, producing hazard.
REQ-034 The PC register, IF/ID register and stall counter SHALL live in if_id_stage.

Verification
REQ-035 Reset with RESET_PC=0, no hazards, 4 edges -> pc_out 4,8,12,16; sumador_IF_ID 4,8,12; valid_IF_ID=1 from edge 1.
REQ-036 IF/ID holds lw-dependent add (rs=8), MemToRead_ID_EX=1, Instruccion_RT_ID_EX=8 -> stall=1 for one cycle, pc_out and instruccion_IF_ID held, stall_count=1.
REQ-037 Same as REQ-036 but Instruccion_RT_ID_EX=0 -> stall=0, normal advance.
REQ-038 branch_taken=1, branch_target=32'h0000_0043, hazard also true -> next pc_out=32'h0000_0040, instruccion_IF_ID=0, valid_IF_ID=0, stall=0, stall_count unchanged.
REQ-039 pc_out=32'hFFFF_FFFC, advance -> pc_out=0, sumador_IF_ID=0.
REQ-040 CNT_W=4, hold hazard 20 cycles -> stall_count saturates at 4'hF; rst_n pulse low between edges -> all outputs reset asynchronously.
